// File: rtl/sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper and its hold timer.
package sweeper_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N_VECTORS = 16;
  localparam int VEC_W     = 4;
  localparam int CNT_W     = 5;

  function automatic logic [N_VECTORS-1:0] put_bit(
    input logic [N_VECTORS-1:0] tbl,
    input logic [VEC_W-1:0]     idx,
    input logic                 b
  );
    logic [N_VECTORS-1:0] res;
    res      = tbl;
    res[idx] = b;
    return res;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bus between a sweep requester and the truth-table sweeper.
interface truth_table_sweeper_if;
  import sweeper_pkg::*;

  logic                 start;
  logic [N_VECTORS-1:0] expected;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_VECTORS-1:0] table_out;
  logic [CNT_W-1:0]     mismatch_count;
  logic                 first_fail_valid;
  logic [VEC_W-1:0]     first_fail_idx;

  modport master (
    output start, expected,
    input  busy, done, pass, table_out, mismatch_count,
           first_fail_valid, first_fail_idx
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, table_out, mismatch_count,
           first_fail_valid, first_fail_idx
  );

endinterface

// File: rtl/truth_table_sweeper_hold_timer.sv
// Per-vector hold counter; expire marks the last cycle a vector is driven.
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [HC_W-1:0] hold_cnt;

  assign expire = (hold_cnt == HC_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_cnt <= '0;
    end else if (enable) begin
      hold_cnt <= expire ? '0 : hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors into a 4-input logic block, captures S per
// vector and checks the captured truth table against a snapshotted reference.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_sweeper_if.slave   bus,
  input  logic                   S,
  output logic                   X1,
  output logic                   X2,
  output logic                   X3,
  output logic                   X4
);

  state_t state, state_nx;
  logic   accept, capture, run, expire;

  logic [VEC_W-1:0]     idx;
  logic [N_VECTORS-1:0] snap;
  logic [N_VECTORS-1:0] table_q;
  logic [CNT_W-1:0]     mm_q;
  logic                 ffv_q;
  logic [VEC_W-1:0]     ffi_q;
  logic                 pass_q;

  logic                 miss;
  logic                 last_vec;
  logic [N_VECTORS-1:0] table_nx;
  logic [CNT_W-1:0]     mm_nx;

  assign run = (state == RUN);

  sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (run),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (expire) begin
          capture = 1'b1;
          if (last_vec) state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next-state view of the results so the final sample is part of pass.
  assign last_vec = (idx == VEC_W'(N_VECTORS - 1));
  assign miss     = (S != snap[idx]);
  assign table_nx = put_bit(table_q, idx, S);
  assign mm_nx    = mm_q + {{(CNT_W-1){1'b0}}, miss};

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      snap    <= '0;
      table_q <= '0;
      mm_q    <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      snap    <= bus.expected;
      table_q <= '0;
      mm_q    <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else if (capture) begin
      table_q <= table_nx;
      mm_q    <= mm_nx;
      if (miss && !ffv_q) begin
        ffv_q <= 1'b1;
        ffi_q <= idx;
      end
      if (last_vec) pass_q <= (table_nx == snap);
      else          idx    <= idx + 1'b1;
    end
  end

  // idx is a register and stays at 15 in DONE, so X needs no extra staging.
  assign {X4, X3, X2, X1}     = idx;
  assign bus.busy             = run;
  assign bus.done             = (state == DONE);
  assign bus.pass             = pass_q;
  assign bus.table_out        = table_q;
  assign bus.mismatch_count   = mm_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: one sweeper with HOLD_CYCLES=4 and one with HOLD_CYCLES=1.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  truth_table_sweeper_if bus4 ();
  truth_table_sweeper_if bus1 ();

  logic s4, s1;
  logic a_x1, a_x2, a_x3, a_x4;
  logic b_x1, b_x2, b_x3, b_x4;
  int   mode4;   // 0 parity, 1 stuck-at-0
  logic s1_val;

  always_comb begin
    s4 = 1'b0;
    if (mode4 == 0) s4 = a_x1 ^ a_x2 ^ a_x3 ^ a_x4;
  end
  assign s1 = s1_val;

  truth_table_sweeper #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .S(s4),
    .X1(a_x1), .X2(a_x2), .X3(a_x3), .X4(a_x4)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .S(s1),
    .X1(b_x1), .X2(b_x2), .X3(b_x3), .X4(b_x4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared4(input string tag);
    check({tag, ".busy"}, 32'(bus4.busy), 32'd0);
    check({tag, ".done"}, 32'(bus4.done), 32'd0);
    check({tag, ".pass"}, 32'(bus4.pass), 32'd0);
    check({tag, ".table"}, 32'(bus4.table_out), 32'h0);
    check({tag, ".mm"}, 32'(bus4.mismatch_count), 32'd0);
    check({tag, ".ffv"}, 32'(bus4.first_fail_valid), 32'd0);
    check({tag, ".ffi"}, 32'(bus4.first_fail_idx), 32'd0);
    check({tag, ".x"}, 32'({a_x4, a_x3, a_x2, a_x1}), 32'h0);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (!bus4.done && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (!bus1.done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_parity_results4(input string tag);
    check({tag, ".done"}, 32'(bus4.done), 32'd1);
    check({tag, ".busy"}, 32'(bus4.busy), 32'd0);
    check({tag, ".table"}, 32'(bus4.table_out), 32'h6996);
    check({tag, ".pass"}, 32'(bus4.pass), 32'd1);
    check({tag, ".mm"}, 32'(bus4.mismatch_count), 32'd0);
    check({tag, ".ffv"}, 32'(bus4.first_fail_valid), 32'd0);
    check({tag, ".x"}, 32'({a_x4, a_x3, a_x2, a_x1}), 32'hF);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus4.start = 1'b1; bus4.expected = 16'h6996;
    bus1.start = 1'b1; bus1.expected = 16'hFFFF;
    mode4 = 0; s1_val = 1'b1;

    // Reset held 3 cycles with start asserted
    tick(); check_cleared4("rst1");
    tick(); check_cleared4("rst2");
    tick(); check_cleared4("rst3");
    check("rst.dut1_busy", 32'(bus1.busy), 32'd0);
    rst = 1'b0; bus4.start = 1'b0; bus1.start = 1'b0;
    tick(); check_cleared4("idle");

    // Parity sweep
    bus4.start = 1'b1;
    tick(); bus4.start = 1'b0;
    check("par.busy", 32'(bus4.busy), 32'd1);
    check("par.x0", 32'({a_x4, a_x3, a_x2, a_x1}), 32'h0);
    tick(); tick(); tick();
    check("par.x0_hold", 32'({a_x4, a_x3, a_x2, a_x1}), 32'h0);
    check("par.busy_hold", 32'(bus4.busy), 32'd1);
    tick();
    check("par.x1", 32'({a_x4, a_x3, a_x2, a_x1}), 32'h1);
    wait_done4(n);
    check("par.latency", 32'(n + 4), 32'd64);
    check_parity_results4("par");
    tick();
    check("par.done_stable", 32'(bus4.done), 32'd1);
    check("par.table_stable", 32'(bus4.table_out), 32'h6996);

    // Stuck-at-0, started from DONE
    mode4 = 1;
    bus4.start = 1'b1;
    tick(); bus4.start = 1'b0;
    check("restart.done", 32'(bus4.done), 32'd0);
    check("restart.table", 32'(bus4.table_out), 32'h0);
    check("restart.busy", 32'(bus4.busy), 32'd1);
    wait_done4(n);
    check("sa0.latency", 32'(n), 32'd64);
    check("sa0.table", 32'(bus4.table_out), 32'h0000);
    check("sa0.pass", 32'(bus4.pass), 32'd0);
    check("sa0.mm", 32'(bus4.mismatch_count), 32'd8);
    check("sa0.ffv", 32'(bus4.first_fail_valid), 32'd1);
    check("sa0.ffi", 32'(bus4.first_fail_idx), 32'd1);

    // start and expected disturbed during RUN
    mode4 = 0;
    bus4.expected = 16'h6996;
    bus4.start = 1'b1;
    tick(); bus4.start = 1'b0;
    n = 0;
    while (!bus4.done && n < 400) begin
      bus4.start = (n == 9);
      if (n == 19) bus4.expected = 16'hFFFF;
      tick();
      n++;
    end
    bus4.start = 1'b0;
    check("rob.latency", 32'(n), 32'd64);
    check_parity_results4("rob");

    // Reset in the middle of vector 7
    bus4.expected = 16'h6996;
    bus4.start = 1'b1;
    tick(); bus4.start = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    check("mid.x7", 32'({a_x4, a_x3, a_x2, a_x1}), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared4("mid.rst");
    tick();
    check("mid.idle_busy", 32'(bus4.busy), 32'd0);
    bus4.start = 1'b1;
    tick(); bus4.start = 1'b0;
    wait_done4(n);
    check("mid.latency", 32'(n), 32'd64);
    check_parity_results4("mid");

    // HOLD_CYCLES=1: all ones
    bus1.expected = 16'hFFFF; s1_val = 1'b1;
    bus1.start = 1'b1;
    tick(); bus1.start = 1'b0;
    wait_done1(n);
    check("h1.latency", 32'(n), 32'd16);
    check("h1.table", 32'(bus1.table_out), 32'hFFFF);
    check("h1.pass", 32'(bus1.pass), 32'd1);
    check("h1.mm", 32'(bus1.mismatch_count), 32'd0);

    // HOLD_CYCLES=1: only the last vector disagrees
    bus1.expected = 16'h7FFF;
    bus1.start = 1'b1;
    tick(); bus1.start = 1'b0;
    check("h1.restart_done", 32'(bus1.done), 32'd0);
    wait_done1(n);
    check("h1b.latency", 32'(n), 32'd16);
    check("h1b.table", 32'(bus1.table_out), 32'hFFFF);
    check("h1b.pass", 32'(bus1.pass), 32'd0);
    check("h1b.mm", 32'(bus1.mismatch_count), 32'd1);
    check("h1b.ffv", 32'(bus1.first_fail_valid), 32'd1);
    check("h1b.ffi", 32'(bus1.first_fail_idx), 32'd15);
    check("h1b.x", 32'({b_x4, b_x3, b_x2, b_x1}), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around the 4-input combinational logic block (X1..X4 -> S).
- Sequences all 16 input vectors {X4,X3,X2,X1} = 0..15 in order and holds each for a programmable number of cycles.
- Samples S at the end of each hold and assembles the 16-bit captured truth table.
- Compares the captured table against an expected table and reports pass/fail, the mismatch count and the first failing vector, for on-chip self-check of the logic block.

Parameters:
- HOLD_CYCLES, default 4: cycles each vector is driven before S is sampled; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle sweep request; honoured only in IDLE or DONE
- expected  input  16  expected truth table, bit i = S for vector i; snapshotted when start is accepted
- S  input  1  output of the logic block under test
- X1  output  1  vector bit 0 (LSB)
- X2  output  1  vector bit 1
- X3  output  1  vector bit 2
- X4  output  1  vector bit 3 (MSB)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE; results valid
- pass  output  1  valid with done; 1 iff captured table == expected snapshot
- table_out  output  16  captured truth table, bit i = S sampled for vector i
- mismatch_count  output  5  number of differing bits, 0..16
- first_fail_valid  output  1  at least one mismatch recorded
- first_fail_idx  output  4  lowest vector index that mismatched

Behaviour:
- Reset (synchronous, rst=1 at a rising edge), every output 0:
  - X1..X4=0, busy=0, done=0, pass=0.
  - table_out=0, mismatch_count=0, first_fail_valid=0, first_fail_idx=0.
  - State returns to IDLE.
  - rst has priority over start and over any in-progress sweep.
- FSM states: IDLE, RUN, DONE.
- IDLE: X=0000. On start=1:
  - Snapshot expected.
  - Clear table_out, mismatch_count, first_fail_valid and first_fail_idx.
  - Set idx=0, hold_cnt=0, go to RUN.
- RUN:
  - X outputs are registered copies of idx, so S settles within the cycle.
  - hold_cnt increments every cycle.
  - When hold_cnt == HOLD_CYCLES-1:
    - table_out[idx] <= S.
    - If S != snapshot[idx]: mismatch_count increments; if first_fail_valid=0, set first_fail_idx=idx and first_fail_valid=1.
    - If idx==15: go to DONE and set pass. pass must include the final sample in the compare (compute from next-state values).
    - Otherwise: idx increments, hold_cnt resets to 0.
  - start is ignored in RUN. Changes on expected are ignored (snapshot only).
- DONE:
  - done=1; pass, table_out and counts held stable.
  - X holds 1111 (last vector).
  - start=1 behaves exactly as start in IDLE (immediate restart, done drops next cycle).
  - No automatic return to IDLE.
- Latency: the edge that samples start enters RUN, and vector 0 appears after that edge. done is observed high after the 16*HOLD_CYCLES-th subsequent rising edge, i.e. 64 edges for HOLD_CYCLES=4.
- Widths:
  - hold_cnt is $clog2(HOLD_CYCLES), minimum 1 bit; it never exceeds HOLD_CYCLES-1.
  - idx is 4 bits and never wraps inside a sweep.
  - mismatch_count is 5 bits so that 16 is representable.
- Reset mid-sweep: all state is discarded; partial results are not retained.

Decomposition:
- Shared package sweeper_pkg:
  - State enum {IDLE, RUN, DONE}.
  - N_VECTORS=16, VEC_W=4, CNT_W=5.
- One sub-module, sweep_hold_timer:
  - Holds the hold_cnt counter and its parameter.
  - Inputs: clear, enable. Output: expire pulse when hold_cnt == HOLD_CYCLES-1.
- The top level holds the FSM, idx, capture register and compare logic.

Test Plan:
- Reset: hold rst for 3 cycles with start=1 -> all outputs 0, state IDLE, X=0000 throughout.
- Parity DUT: S=X1^X2^X3^X4, expected=16'h6996, HOLD_CYCLES=4, one start pulse -> each vector held 4 cycles, busy for 64 cycles, done=1, table_out=16'h6996, pass=1, mismatch_count=0, first_fail_valid=0.
- Stuck-at-0: S=0, expected=16'h6996 -> table_out=16'h0000, pass=0, mismatch_count=8, first_fail_valid=1, first_fail_idx=1.
- Robustness during RUN: pulse start at cycle 10 and change expected to 16'hFFFF at cycle 20 of the parity run -> no restart, final results identical to the parity scenario.
- Mid-sweep reset: assert rst while idx=7 -> next edge all outputs 0, state IDLE; a new start then completes a full 64-cycle sweep with correct results.
- Restart from DONE and boundary: start in DONE -> done=0 and table_out cleared the next cycle. With HOLD_CYCLES=1, a new sweep finishes in 16 cycles and the last vector is still compared (expected=16'hFFFF, S=1 -> pass=1).
